// File: rtl/pkt_gen_pkg.sv
// rtl/pkt_gen_pkg.sv - shared types and defaults for the pkt_gen packet source
package pkt_gen_pkg;

   typedef enum logic [1:0] {PKT_IDLE_S, PKT_PAYLOAD_S, PKT_GAP_S} pkt_state_t;
   typedef enum logic {PKT_MODE_MEM, PKT_MODE_INC} pkt_mode_t;

   localparam int FRAME_BYTES = 42;
   localparam int IPG_DEF     = 10;

endpackage

// File: rtl/pkt_gen_mem.sv
// rtl/pkt_gen_mem.sv - frame memory: one synchronous write port, combinational read
module pkt_gen_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_a,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_a) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pkt_gen.sv
// rtl/pkt_gen.sv - configurable packet source with ready/valid, SOF/EOF framing and abort
module pkt_gen
   import pkt_gen_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   parameter int CNT_W = 16,
   parameter int IPG_W = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = $clog2(DEPTH + 1)
) (
   input  logic             clk_a,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             abort,
   input  logic [LW-1:0]    cfg_len,
   input  logic [IPG_W-1:0] cfg_ipg,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             cfg_mode,
   input  logic             data_ready,
   output logic             data_valid_a,
   output logic [WIDTH-1:0] data_a,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pkt_cnt
);

   pkt_state_t       state;
   pkt_mode_t        mode_q;
   logic [LW-1:0]    len_q, k, last_k, start_len;
   logic [IPG_W-1:0] ipg_q, gap_cnt;
   logic [CNT_W-1:0] count_q, pkt_next;
   logic             mem_we, at_eof;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data, mem_word;

   assign mem_we   = wr_en && (state == PKT_IDLE_S);
   assign last_k   = len_q - LW'(1);
   assign at_eof   = (k == last_k);
   assign pkt_next = pkt_cnt + CNT_W'(1);

   // Read address always points at the word that will be loaded on the next edge.
   assign rd_addr  = (state == PKT_PAYLOAD_S && !at_eof) ? AW'(k + LW'(1)) : '0;
   // Bypass lets a write coinciding with start feed the first word.
   assign mem_word = (mem_we && wr_addr == rd_addr) ? wr_data : rd_data;

   always_comb begin
      start_len = cfg_len;
      if (cfg_len == '0) start_len = LW'(1);
      else if (cfg_len > LW'(DEPTH)) start_len = LW'(DEPTH);
   end

   function automatic logic [WIDTH-1:0] word_val(input pkt_mode_t m, input logic [CNT_W-1:0] p,
                                                 input logic [LW-1:0] idx, input logic [WIDTH-1:0] mw);
      return (m == PKT_MODE_INC) ? WIDTH'(p) + WIDTH'(idx) : mw;
   endfunction

   pkt_gen_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk_a   (clk_a),
      .wr_en   (mem_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) begin
         state        <= PKT_IDLE_S;
         mode_q       <= PKT_MODE_MEM;
         len_q        <= '0;
         k            <= '0;
         ipg_q        <= '0;
         gap_cnt      <= '0;
         count_q      <= '0;
         pkt_cnt      <= '0;
         done         <= 1'b0;
         busy         <= 1'b0;
         data_valid_a <= 1'b0;
         data_a       <= '0;
         sof          <= 1'b0;
         eof          <= 1'b0;
      end else if (abort) begin
         state        <= PKT_IDLE_S;
         busy         <= 1'b0;
         data_valid_a <= 1'b0;
         sof          <= 1'b0;
         eof          <= 1'b0;
      end else begin
         case (state)
            PKT_IDLE_S: begin
               if (start) begin
                  mode_q       <= pkt_mode_t'(cfg_mode);
                  len_q        <= start_len;
                  ipg_q        <= cfg_ipg;
                  count_q      <= cfg_count;
                  pkt_cnt      <= '0;
                  done         <= 1'b0;
                  k            <= '0;
                  state        <= PKT_PAYLOAD_S;
                  busy         <= 1'b1;
                  data_valid_a <= 1'b1;
                  sof          <= 1'b1;
                  eof          <= (start_len == LW'(1));
                  data_a       <= word_val(pkt_mode_t'(cfg_mode), '0, '0, mem_word);
               end
            end
            PKT_PAYLOAD_S: begin
               if (data_ready) begin
                  if (at_eof) begin
                     pkt_cnt <= pkt_next;
                     k       <= '0;
                     if (count_q != '0 && pkt_next == count_q) begin
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= PKT_IDLE_S;
                        data_valid_a <= 1'b0;
                        sof          <= 1'b0;
                        eof          <= 1'b0;
                     end else if (ipg_q == '0) begin
                        sof    <= 1'b1;
                        eof    <= (len_q == LW'(1));
                        data_a <= word_val(mode_q, pkt_next, '0, mem_word);
                     end else begin
                        state        <= PKT_GAP_S;
                        gap_cnt      <= ipg_q;
                        data_valid_a <= 1'b0;
                        sof          <= 1'b0;
                        eof          <= 1'b0;
                     end
                  end else begin
                     k      <= k + LW'(1);
                     sof    <= 1'b0;
                     eof    <= (k + LW'(1) == last_k);
                     data_a <= word_val(mode_q, pkt_cnt, k + LW'(1), mem_word);
                  end
               end
            end
            PKT_GAP_S: begin
               if (gap_cnt == IPG_W'(1)) begin
                  state        <= PKT_PAYLOAD_S;
                  data_valid_a <= 1'b1;
                  sof          <= 1'b1;
                  eof          <= (len_q == LW'(1));
                  data_a       <= word_val(mode_q, pkt_cnt, '0, mem_word);
               end else begin
                  gap_cnt <= gap_cnt - IPG_W'(1);
               end
            end
            default: state <= PKT_IDLE_S;
         endcase
      end
   end

endmodule
